// File: rtl/bp_pkg.sv
// Shared types and helpers for the BTB + PHT branch predictor.
package bp_pkg;

    localparam int unsigned XLEN      = 32;
    // Widest possible tag (1-entry BTB); narrower tags are zero-extended into it.
    localparam int unsigned TAG_MAX_W = 30;
    localparam int unsigned CNT_MAX_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [XLEN-1:0]      target;
        logic                 is_jump;
    } btb_entry_t;

    localparam btb_entry_t BTB_ENTRY_RST = '{
        valid:   1'b0,
        tag:     {TAG_MAX_W{1'b0}},
        target:  32'd0,
        is_jump: 1'b0
    };

    // Word index of a PC, masked to idx_w bits (caller narrows to its index width).
    function automatic logic [31:0] pc_index(input logic [31:0] pc, input int unsigned idx_w);
        logic [31:0] mask;
        mask = (32'd1 << idx_w) - 32'd1;
        return (pc >> 2) & mask;
    endfunction

    // Tag bits above the word index, zero-extended to TAG_MAX_W.
    function automatic logic [TAG_MAX_W-1:0] pc_tag(input logic [31:0] pc, input int unsigned idx_w);
        return TAG_MAX_W'(pc >> (idx_w + 32'd2));
    endfunction

    // Weakly-not-taken reset value for a cnt_w-bit counter.
    function automatic logic [CNT_MAX_W-1:0] cnt_reset(input int unsigned cnt_w);
        return CNT_MAX_W'((32'd1 << (cnt_w - 32'd1)) - 32'd1);
    endfunction

    // Saturation ceiling for a cnt_w-bit counter.
    function automatic logic [CNT_MAX_W-1:0] cnt_max(input int unsigned cnt_w);
        return CNT_MAX_W'((32'd1 << cnt_w) - 32'd1);
    endfunction

endpackage

// File: rtl/bp_pht.sv
// Pattern history table: array of saturating counters with one read and one update port.
module bp_pht
    import bp_pkg::*;
#(
    parameter int unsigned ENTRIES = 256,
    parameter int unsigned IDX_W   = $clog2(ENTRIES),
    parameter int unsigned CNT_W   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    localparam logic [CNT_W-1:0] CNT_RST  = CNT_W'(cnt_reset(CNT_W));
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [ENTRIES];
    logic [CNT_W-1:0] cnt_d [ENTRIES];
    logic [CNT_W-1:0] cur_s;

    // Counter MSB is the taken prediction; reads see pre-update contents.
    assign rd_taken_o = cnt_q[rd_idx_i][CNT_W-1];

    // Saturating increment/decrement of the resolved branch's counter.
    always_comb begin
        cnt_d = cnt_q;
        cur_s = cnt_q[upd_idx_i];
        if (upd_en_i) begin
            if (upd_taken_i) begin
                if (cur_s != CNT_SAT) begin
                    cnt_d[upd_idx_i] = cur_s + CNT_ONE;
                end else begin
                    cnt_d[upd_idx_i] = cur_s;
                end
            end else begin
                if (cur_s != CNT_ZERO) begin
                    cnt_d[upd_idx_i] = cur_s - CNT_ONE;
                end else begin
                    cnt_d[upd_idx_i] = cur_s;
                end
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter storage; reset takes priority over a coincident update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt_q[i] <= CNT_RST;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with bimodal/gshare PHT, EX-stage resolve and perf counters.
module branch_predictor_btb
    import bp_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned PHT_ENTRIES = 256,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned GHR_W       = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    output logic        hit_o,
    output logic        pred_taken_o,
    output logic [31:0] predicted_pc_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_is_branch_i,
    input  logic        upd_is_jump_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    input  logic        upd_pred_taken_i,
    input  logic [31:0] upd_pred_pc_i,
    output logic        mispredict_o,
    output logic [31:0] redirect_pc_o,
    output logic [31:0] br_cnt_o,
    output logic [31:0] mispred_cnt_o
);

    localparam int unsigned BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned PHT_IDX_W = $clog2(PHT_ENTRIES);
    localparam int unsigned GHR_BITS  = (GHR_W > 0) ? GHR_W : 1;

    btb_entry_t btb_q [BTB_ENTRIES];
    btb_entry_t btb_d [BTB_ENTRIES];
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [31:0]         br_cnt_q, br_cnt_d;
    logic [31:0]         mp_cnt_q, mp_cnt_d;

    logic [BTB_IDX_W-1:0] lk_idx_s, up_idx_s;
    logic [TAG_MAX_W-1:0] lk_tag_s, up_tag_s;
    logic [PHT_IDX_W-1:0] ghr_ext_s, lk_pht_idx_s, up_pht_idx_s;
    btb_entry_t           lk_entry_s;
    logic                 lk_pht_taken_s;
    logic                 up_hit_s;
    logic                 ctrl_s;
    logic [31:0]          actual_next_s;

    // The direction bit is implied by upd_pred_pc_i, which already decides mispredicts.
    logic unused_pred_taken_s;
    assign unused_pred_taken_s = upd_pred_taken_i;

    // Index/tag extraction for both the fetch lookup and the EX update port.
    always_comb begin
        lk_idx_s     = BTB_IDX_W'(pc_index(pc_i, BTB_IDX_W));
        up_idx_s     = BTB_IDX_W'(pc_index(upd_pc_i, BTB_IDX_W));
        lk_tag_s     = pc_tag(pc_i, BTB_IDX_W);
        up_tag_s     = pc_tag(upd_pc_i, BTB_IDX_W);
        ghr_ext_s    = (GHR_W > 0) ? PHT_IDX_W'(ghr_q) : {PHT_IDX_W{1'b0}};
        lk_pht_idx_s = PHT_IDX_W'(pc_index(pc_i, PHT_IDX_W)) ^ ghr_ext_s;
        up_pht_idx_s = PHT_IDX_W'(pc_index(upd_pc_i, PHT_IDX_W)) ^ ghr_ext_s;
    end

    bp_pht #(
        .ENTRIES (PHT_ENTRIES),
        .IDX_W   (PHT_IDX_W),
        .CNT_W   (CNT_W)
    ) u_pht (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rd_idx_i    (lk_pht_idx_s),
        .rd_taken_o  (lk_pht_taken_s),
        .upd_en_i    (upd_valid_i && upd_is_branch_i),
        .upd_idx_i   (up_pht_idx_s),
        .upd_taken_i (upd_taken_i)
    );

    // Zero-latency fetch lookup against pre-update BTB/PHT contents.
    always_comb begin
        lk_entry_s     = btb_q[lk_idx_s];
        hit_o          = lk_entry_s.valid && (lk_entry_s.tag == lk_tag_s);
        pred_taken_o   = hit_o && (lk_entry_s.is_jump || lk_pht_taken_s);
        predicted_pc_o = pred_taken_o ? lk_entry_s.target : (pc_i + 32'd4);
    end

    // EX resolve: compare the real next PC with what fetch assumed.
    always_comb begin
        ctrl_s        = upd_is_branch_i || upd_is_jump_i;
        actual_next_s = (ctrl_s && upd_taken_i) ? upd_target_i : (upd_pc_i + 32'd4);
        mispredict_o  = upd_valid_i && (actual_next_s != upd_pred_pc_i);
        redirect_pc_o = actual_next_s;
        up_hit_s      = btb_q[up_idx_s].valid && (btb_q[up_idx_s].tag == up_tag_s);
    end

    // Next-state for BTB allocation/invalidation, history and perf counters.
    always_comb begin
        btb_d    = btb_q;
        ghr_d    = ghr_q;
        br_cnt_d = br_cnt_q;
        mp_cnt_d = mp_cnt_q;
        if (upd_valid_i) begin
            if (ctrl_s && upd_taken_i) begin
                btb_d[up_idx_s] = '{valid: 1'b1, tag: up_tag_s,
                                    target: upd_target_i, is_jump: upd_is_jump_i};
            end else if (!ctrl_s && up_hit_s) begin
                // A non-control instruction hit: the entry belongs to an alias, drop it.
                btb_d[up_idx_s].valid = 1'b0;
            end else begin
                btb_d[up_idx_s] = btb_q[up_idx_s];
            end
            if (upd_is_branch_i && (GHR_W > 0)) begin
                ghr_d = GHR_BITS'({ghr_q, upd_taken_i});
            end else begin
                ghr_d = ghr_q;
            end
            if (ctrl_s) begin
                br_cnt_d = br_cnt_q + 32'd1;
            end else begin
                br_cnt_d = br_cnt_q;
            end
            if (mispredict_o) begin
                mp_cnt_d = mp_cnt_q + 32'd1;
            end else begin
                mp_cnt_d = mp_cnt_q;
            end
        end else begin
            btb_d = btb_q;
        end
    end

    // State registers; reset beats any coincident update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                btb_q[i] <= BTB_ENTRY_RST;
            end
            ghr_q    <= {GHR_BITS{1'b0}};
            br_cnt_q <= 32'd0;
            mp_cnt_q <= 32'd0;
        end else begin
            btb_q    <= btb_d;
            ghr_q    <= ghr_d;
            br_cnt_q <= br_cnt_d;
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign br_cnt_o      = br_cnt_q;
    assign mispred_cnt_o = mp_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench: bimodal (GHR_W=0) and gshare (GHR_W=4) predictors driven in lockstep
// against a table-level reference model.
module tb_branch_predictor_btb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic [31:0] pc_i;
    logic        upd_valid_i, upd_is_branch_i, upd_is_jump_i, upd_taken_i, upd_pred_taken_i;
    logic [31:0] upd_pc_i, upd_target_i, upd_pred_pc_i;

    logic [1:0]       hit_w, ptk_w, mp_w;
    logic [1:0][31:0] ppc_w, rd_w, brc_w, mpc_w;

    branch_predictor_btb #(.GHR_W(0)) dut_bim (
        .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i),
        .hit_o(hit_w[0]), .pred_taken_o(ptk_w[0]), .predicted_pc_o(ppc_w[0]),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_is_branch_i(upd_is_branch_i),
        .upd_is_jump_i(upd_is_jump_i), .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
        .upd_pred_taken_i(upd_pred_taken_i), .upd_pred_pc_i(upd_pred_pc_i),
        .mispredict_o(mp_w[0]), .redirect_pc_o(rd_w[0]),
        .br_cnt_o(brc_w[0]), .mispred_cnt_o(mpc_w[0])
    );

    branch_predictor_btb #(.GHR_W(4)) dut_gsh (
        .clk_i(clk), .rst_i(rst_i), .pc_i(pc_i),
        .hit_o(hit_w[1]), .pred_taken_o(ptk_w[1]), .predicted_pc_o(ppc_w[1]),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_is_branch_i(upd_is_branch_i),
        .upd_is_jump_i(upd_is_jump_i), .upd_taken_i(upd_taken_i), .upd_target_i(upd_target_i),
        .upd_pred_taken_i(upd_pred_taken_i), .upd_pred_pc_i(upd_pred_pc_i),
        .mispredict_o(mp_w[1]), .redirect_pc_o(rd_w[1]),
        .br_cnt_o(brc_w[1]), .mispred_cnt_o(mpc_w[1])
    );

    int vecs = 0;
    int errs = 0;

    // Reference model: per-design BTB table, counter table and history.
    bit          m_v   [2][64];
    int unsigned m_tag [2][64];
    logic [31:0] m_tgt [2][64];
    bit          m_j   [2][64];
    int          m_pht [2][256];
    int unsigned m_ghr [2];
    logic [31:0] m_br, m_mp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned bidx(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd64);
    endfunction

    function automatic int unsigned btag(input logic [31:0] pc);
        return int'(pc / 32'd256);
    endfunction

    function automatic int unsigned pidx(input int d, input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd256) ^ m_ghr[d];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 64; i++) m_v[d][i] = 1'b0;
            for (int i = 0; i < 256; i++) m_pht[d][i] = 1;
            m_ghr[d] = 0;
        end
        m_br = 32'd0;
        m_mp = 32'd0;
    endtask

    task automatic predict(input int d, input logic [31:0] pc,
                           output bit hit, output bit tk, output logic [31:0] npc);
        int unsigned i;
        i   = bidx(pc);
        hit = m_v[d][i] && (m_tag[d][i] == btag(pc));
        tk  = hit && (m_j[d][i] || (m_pht[d][pidx(d, pc)] >= 2));
        npc = tk ? m_tgt[d][i] : pc + 32'd4;
    endtask

    // One cycle: apply inputs, check lookup/resolve, clock, check counters.
    task automatic step(input logic [31:0] fpc, input bit v, input logic [31:0] upc,
                        input bit br, input bit jp, input bit tk,
                        input logic [31:0] tgt, input logic [31:0] ppc);
        bit          h, t, ctrl, emp, uhit;
        logic [31:0] n, actual;
        int unsigned i, p;
        pc_i = fpc; upd_valid_i = v; upd_pc_i = upc; upd_is_branch_i = br;
        upd_is_jump_i = jp; upd_taken_i = tk; upd_target_i = tgt; upd_pred_pc_i = ppc;
        upd_pred_taken_i = (ppc != upc + 32'd4);
        #1;
        ctrl   = br || jp;
        actual = (ctrl && tk) ? tgt : upc + 32'd4;
        emp    = v && (actual != ppc);
        for (int d = 0; d < 2; d++) begin
            predict(d, fpc, h, t, n);
            chk($sformatf("hit[%0d]", d), 32'(hit_w[d]), 32'(h));
            chk($sformatf("pred_taken[%0d]", d), 32'(ptk_w[d]), 32'(t));
            chk($sformatf("pred_pc[%0d]", d), ppc_w[d], n);
            chk($sformatf("mispredict[%0d]", d), 32'(mp_w[d]), 32'(emp));
            if (emp) chk($sformatf("redirect[%0d]", d), rd_w[d], actual);
        end
        @(posedge clk);
        if (v) begin
            for (int d = 0; d < 2; d++) begin
                i    = bidx(upc);
                uhit = m_v[d][i] && (m_tag[d][i] == btag(upc));
                if (ctrl && tk) begin
                    m_v[d][i] = 1'b1; m_tag[d][i] = btag(upc);
                    m_tgt[d][i] = tgt; m_j[d][i] = jp;
                end else if (!ctrl && uhit) begin
                    m_v[d][i] = 1'b0;
                end
                if (br) begin
                    p = pidx(d, upc);
                    if (tk && m_pht[d][p] < 3) m_pht[d][p]++;
                    if (!tk && m_pht[d][p] > 0) m_pht[d][p]--;
                    if (d == 1) m_ghr[d] = ((m_ghr[d] << 1) | 32'(tk)) % 16;
                end
            end
            if (ctrl) m_br = m_br + 32'd1;
            if (emp) m_mp = m_mp + 32'd1;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("br_cnt[%0d]", d), brc_w[d], m_br);
            chk($sformatf("mispred_cnt[%0d]", d), mpc_w[d], m_mp);
        end
    endtask

    initial begin
        bit          h, t;
        logic [31:0] n, snap, upc, fpc, tgt, ppc;
        bit          br, jp, tk, v;
        int unsigned kind;

        rst_i = 1'b1; pc_i = 32'h100; upd_valid_i = 1'b0; upd_pc_i = 32'd0;
        upd_is_branch_i = 1'b0; upd_is_jump_i = 1'b0; upd_taken_i = 1'b0;
        upd_target_i = 32'd0; upd_pred_taken_i = 1'b0; upd_pred_pc_i = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();

        // Reset state
        step(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        chk("reset_pred_pc", ppc_w[0], 32'h104);

        // Taken branch allocation, then lookup
        step(32'h100, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h180, 32'h204);
        step(32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        chk("alloc_pred_pc", ppc_w[0], 32'h180);

        // Not-taken training down to saturation
        step(32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h180, 32'h180);
        step(32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h180, 32'h204);
        step(32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h180, 32'h204);
        step(32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);

        // Jump allocation predicts target regardless of counters
        step(32'h300, 1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 32'h400, 32'h304);
        step(32'h300, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        chk("jump_pred_pc", ppc_w[1], 32'h400);

        // Re-allocate 0x200, then aliasing non-control instructions
        step(32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 32'h180, 32'h204);
        step(32'h1200, 1'b1, 32'h1200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1204);
        step(32'h200, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h180);
        step(32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        chk("alias_invalidated", 32'(hit_w[0]), 32'd0);

        // Alternating branch: gshare learns the pattern
        snap = 32'd0;
        for (int k = 0; k < 16; k++) begin
            predict(1, 32'h500, h, t, n);
            step(32'h500, 1'b1, 32'h500, 1'b1, 1'b0, (k % 2) == 0, 32'h580, n);
            if (k == 7) snap = mpc_w[1];
        end
        chk("gshare_warm_mispredicts", mpc_w[1] - snap, 32'd0);

        // Reset during a live update: no write survives
        pc_i = 32'h700; upd_valid_i = 1'b1; upd_pc_i = 32'h700; upd_is_branch_i = 1'b1;
        upd_is_jump_i = 1'b0; upd_taken_i = 1'b1; upd_target_i = 32'h900;
        upd_pred_pc_i = 32'h704; rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        model_reset();
        step(32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        step(32'h500, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);
        chk("post_reset_br_cnt", brc_w[0], 32'd0);

        // Randomized traffic over a small, heavily aliased PC pool
        for (int k = 0; k < 400; k++) begin
            upc  = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 7)) << 2);
            fpc  = ($urandom_range(0, 3) == 0) ? upc
                 : ((32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 7)) << 2));
            kind = $urandom_range(0, 3);
            br   = (kind <= 1);
            jp   = (kind == 2);
            tk   = jp || (br && ($urandom_range(0, 1) == 1));
            tgt  = 32'($urandom_range(0, 255)) << 2;
            v    = ($urandom_range(0, 7) != 0);
            predict(0, upc, h, t, n);
            case ($urandom_range(0, 2))
                0:       ppc = n;
                1:       ppc = upc + 32'd4;
                default: ppc = tgt;
            endcase
            step(fpc, v, upc, br, jp, tk, tgt, ppc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
